// File: rtl/simd_pkg.sv
// Shared types and sizes for the SIMD issue sequencer slice.
// Optional feature macro: LANE_MASK_EN (per-lane skip during scalar stepping).
package simd_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned ADDR_W    = 8;

  localparam logic [ADDR_W-1:0] PC_RESET_ADDR = 8'd15;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/simd_issue_sequencer_if.sv
// Fetch-side / PC-side signal bundle of the issue sequencer.
// Optional feature macro: LANE_MASK_EN (lane_mask only consumed when defined).
interface simd_issue_sequencer_if;
  import simd_pkg::*;

  logic                 instr_valid;
  logic                 instr_is_vector;
  logic                 stall;
  logic                 branch_taken;
  logic [ADDR_W-1:0]    branch_target;
  logic [NUM_LANES-1:0] lane_mask;

  logic [LANE_W-1:0]    lane_offset;
  logic [NUM_LANES-1:0] lane_enable;
  logic                 issue_valid;
  logic                 pc_vector;
  logic [LANE_W-1:0]    pc_offset;
  logic                 pc_reset;
  logic                 jump_enable;
  logic [ADDR_W-1:0]    jump_address;
  logic                 busy;

  // Fetch / testbench side
  modport master (
    output instr_valid, instr_is_vector, stall, branch_taken, branch_target, lane_mask,
    input  lane_offset, lane_enable, issue_valid, pc_vector, pc_offset, pc_reset,
           jump_enable, jump_address, busy
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instr_is_vector, stall, branch_taken, branch_target, lane_mask,
    output lane_offset, lane_enable, issue_valid, pc_vector, pc_offset, pc_reset,
           jump_enable, jump_address, busy
  );

endinterface

// File: rtl/simd_issue_sequencer_lane_stepper.sv
// Scalar lane counter with current-lane / last-lane decode.
// Optional feature macro: LANE_MASK_EN (skip lanes whose mask bit is 0).
module simd_issue_sequencer_lane_stepper
  import simd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic [NUM_LANES-1:0] lane_mask,
  output logic [LANE_W-1:0]    cnt,
  output logic [LANE_W-1:0]    lane_c,
  output logic                 last_c,
  output logic [NUM_LANES-1:0] lane_en_c,
  output logic [NUM_LANES-1:0] vec_en_c
);

`ifdef LANE_MASK_EN
  logic [NUM_LANES-1:0] mask_q;
  logic [NUM_LANES-1:0] cur_mask;
  logic [LANE_W-1:0]    nxt_lane;
  logic                 found;

  // Counter 0 marks an instruction boundary, so the live mask applies there
  assign cur_mask = (cnt == '0) ? lane_mask : mask_q;

  // Current lane is the first set bit at the boundary; next lane is the next set bit above it
  always_comb begin
    lane_c   = cnt;
    nxt_lane = '0;
    found    = 1'b0;
    if (cnt == '0) begin
      lane_c = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (cur_mask[i]) lane_c = LANE_W'(i);
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!found && cur_mask[i] && (LANE_W'(i) > lane_c)) begin
        nxt_lane = LANE_W'(i);
        found    = 1'b1;
      end
    end
    last_c    = ~found;
    lane_en_c = cur_mask & (NUM_LANES'(1) << lane_c);
    vec_en_c  = cur_mask;
  end

  // Counter jumps to the next active lane; mask captured on the first beat
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mask_q <= '0;
    end else if (step) begin
      cnt <= last_c ? '0 : nxt_lane;
      if (cnt == '0) mask_q <= lane_mask;
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^lane_mask;

  // Every lane steps; lane 3 closes the instruction
  always_comb begin
    lane_c    = cnt;
    last_c    = (cnt == LANE_W'(NUM_LANES - 1));
    lane_en_c = NUM_LANES'(1) << cnt;
    vec_en_c  = '1;
  end

  // Counter wraps 3 -> 0 on each scalar beat
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (step) cnt <= cnt + LANE_W'(1);
  end
`endif

endmodule

// File: rtl/simd_issue_sequencer.sv
// Issue controller for the 4-lane SIMD array and its program counter.
// Optional feature macro: LANE_MASK_EN (masked scalar stepping, masked vector enable).
module simd_issue_sequencer
  import simd_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  simd_issue_sequencer_if.slave bus
);

  state_t               state;
  logic [ADDR_W-1:0]    tgt_q;
  logic [LANE_W-1:0]    cnt;
  logic [LANE_W-1:0]    lane_c;
  logic                 last_c;
  logic [NUM_LANES-1:0] lane_en_c;
  logic [NUM_LANES-1:0] vec_en_c;
  logic                 fire;
  logic                 vec_beat;
  logic                 sc_beat;
  logic                 final_beat;
  logic                 jump_c;

  simd_issue_sequencer_lane_stepper u_stepper (
    .clk       (clk),
    .reset     (reset),
    .step      (sc_beat),
    .lane_mask (bus.lane_mask),
    .cnt       (cnt),
    .lane_c    (lane_c),
    .last_c    (last_c),
    .lane_en_c (lane_en_c),
    .vec_en_c  (vec_en_c)
  );

  // Beat qualification; instruction kind only honoured at a boundary
  always_comb begin
    fire       = (state == RUN) & bus.instr_valid & ~bus.stall & ~reset;
    vec_beat   = fire & bus.instr_is_vector & (cnt == '0);
    sc_beat    = fire & ~vec_beat;
    final_beat = vec_beat | (sc_beat & last_c);
    jump_c     = final_beat & bus.branch_taken;
  end

  // Issue and PC control outputs
  always_comb begin
    bus.issue_valid  = fire;
    bus.pc_reset     = reset;
    bus.pc_vector    = reset | vec_beat;
    bus.lane_enable  = '0;
    bus.lane_offset  = '0;
    bus.pc_offset    = '0;
    bus.jump_enable  = jump_c;
    bus.jump_address = jump_c ? bus.branch_target : tgt_q;
    bus.busy         = (cnt != '0) | (state == FLUSH);
    if (vec_beat) begin
      bus.lane_enable = vec_en_c;
    end else if (sc_beat) begin
      bus.lane_enable = lane_en_c;
      bus.lane_offset = lane_c;
      bus.pc_offset   = last_c ? LANE_W'(NUM_LANES - 1) : lane_c;
    end
  end

  // Run/flush state and last final-beat target
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      tgt_q <= '0;
    end else begin
      if (final_beat) tgt_q <= bus.branch_target;
      case (state)
        RUN:     if (jump_c) state <= FLUSH;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_issue_sequencer.sv
// Directed bench for simd_issue_sequencer with a small gated-PC model.
// Optional feature macro: LANE_MASK_EN (adds masked-stepping steps).
module tb_simd_issue_sequencer;
  import simd_pkg::*;

  logic clk;
  logic reset;
  logic [ADDR_W-1:0] pc;
  int unsigned pass_cnt;
  int unsigned total_cnt;

  simd_issue_sequencer_if bif ();

  simd_issue_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PC: reload on reset, jump, or step on a final beat
  always_ff @(posedge clk) begin
    if (bif.pc_reset && bif.pc_vector) pc <= PC_RESET_ADDR;
    else if (bif.jump_enable) pc <= bif.jump_address;
    else if (bif.pc_vector || (bif.pc_offset == 2'b11)) pc <= pc + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs at the falling edge, settle before checking
  task automatic drive(input logic rst, input logic v, input logic vec, input logic st,
                       input logic br, input logic [7:0] tgt);
    @(negedge clk);
    reset               = rst;
    bif.instr_valid     = v;
    bif.instr_is_vector = vec;
    bif.stall           = st;
    bif.branch_taken    = br;
    bif.branch_target   = tgt;
    #1;
  endtask

  initial begin
    pass_cnt            = 0;
    total_cnt           = 0;
    reset               = 1'b1;
    bif.instr_valid     = 1'b0;
    bif.instr_is_vector = 1'b0;
    bif.stall           = 1'b0;
    bif.branch_taken    = 1'b0;
    bif.branch_target   = 8'h00;
    bif.lane_mask       = 4'hF;

    // Reset cycle with a vector instruction pending
    drive(1, 1, 1, 0, 0, 8'h00);
    chk("rst_pc_reset", bif.pc_reset, 1);
    chk("rst_pc_vector", bif.pc_vector, 1);
    chk("rst_issue", bif.issue_valid, 0);
    chk("rst_lane_en", bif.lane_enable, 0);
    chk("rst_jump", bif.jump_enable, 0);
    chk("rst_pc_off", bif.pc_offset, 0);
    chk("rst_lane_off", bif.lane_offset, 0);

    // Vector beat at PC 15
    drive(0, 1, 1, 0, 0, 8'h00);
    chk("vec_pc", pc, 15);
    chk("vec_issue", bif.issue_valid, 1);
    chk("vec_lane_en", bif.lane_enable, 4'hF);
    chk("vec_pc_vector", bif.pc_vector, 1);
    chk("vec_busy", bif.busy, 0);
    chk("vec_pc_reset", bif.pc_reset, 0);

    // Scalar instruction, four consecutive beats
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, 0, 8'h00);
      chk($sformatf("sc_pc_%0d", k), pc, 16);
      chk($sformatf("sc_lane_off_%0d", k), bif.lane_offset, k);
      chk($sformatf("sc_lane_en_%0d", k), bif.lane_enable, 32'd1 << k);
      chk($sformatf("sc_pc_off_%0d", k), bif.pc_offset, k);
      chk($sformatf("sc_pc_vec_%0d", k), bif.pc_vector, 0);
      chk($sformatf("sc_busy_%0d", k), bif.busy, (k != 0) ? 1 : 0);
    end

    // Scalar with stalls at lane 2 and lane 3
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("st_pc_start", pc, 17);
    chk("st_lane0", bif.lane_enable, 4'b0001);
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("st_lane1", bif.lane_enable, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 1, 0, 8'h00);
      chk($sformatf("st2_issue_%0d", k), bif.issue_valid, 0);
      chk($sformatf("st2_lane_en_%0d", k), bif.lane_enable, 0);
      chk($sformatf("st2_busy_%0d", k), bif.busy, 1);
    end
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("st_lane2_off", bif.lane_offset, 2);
    chk("st_lane2_pc_off", bif.pc_offset, 2);
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 1, 0, 8'h00);
      chk($sformatf("st3_lane_en_%0d", k), bif.lane_enable, 0);
      chk($sformatf("st3_pc_off_%0d", k), bif.pc_offset, 0);
      chk($sformatf("st3_pc_%0d", k), pc, 17);
    end
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("st_lane3_off", bif.lane_offset, 3);
    chk("st_lane3_pc_off", bif.pc_offset, 3);
    chk("st_lane3_pc", pc, 17);

    // Vector with taken branch to 0x40
    drive(0, 1, 1, 0, 1, 8'h40);
    chk("br_pc_before", pc, 18);
    chk("br_jump", bif.jump_enable, 1);
    chk("br_addr", bif.jump_address, 8'h40);
    chk("br_issue", bif.issue_valid, 1);
    drive(0, 1, 1, 0, 0, 8'h77);
    chk("fl_pc", pc, 8'h40);
    chk("fl_issue", bif.issue_valid, 0);
    chk("fl_busy", bif.busy, 1);
    chk("fl_jump", bif.jump_enable, 0);
    chk("fl_addr_held", bif.jump_address, 8'h40);
    drive(0, 1, 1, 0, 0, 8'h00);
    chk("res_issue", bif.issue_valid, 1);
    chk("res_busy", bif.busy, 0);
    chk("res_lane_en", bif.lane_enable, 4'hF);

    // Scalar with branch only on a non-final beat: no jump
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("sb_pc", pc, 8'h41);
    drive(0, 1, 0, 0, 1, 8'h90);
    chk("sb_jump_l1", bif.jump_enable, 0);
    drive(0, 1, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("sb_jump_l3", bif.jump_enable, 0);
    chk("sb_pc_off_l3", bif.pc_offset, 3);
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("sb_pc_after", pc, 8'h42);
    chk("sb_no_flush", bif.issue_valid, 1);
    chk("sb_next_lane0", bif.lane_offset, 0);

    // Reset at lane 2 abandons the sequence
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("rs_lane1", bif.lane_offset, 1);
    drive(1, 1, 0, 0, 0, 8'h00);
    chk("rs_issue", bif.issue_valid, 0);
    chk("rs_pc_reset", bif.pc_reset, 1);
    chk("rs_pc_vector", bif.pc_vector, 1);
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("rs_pc", pc, 15);
    chk("rs_lane_off", bif.lane_offset, 0);
    chk("rs_lane_en", bif.lane_enable, 4'b0001);
    chk("rs_busy", bif.busy, 0);

`ifdef LANE_MASK_EN
    // Masked stepping: restart at a boundary
    drive(1, 0, 0, 0, 0, 8'h00);
    bif.lane_mask = 4'b0101;
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("mk_lane0_off", bif.lane_offset, 0);
    chk("mk_lane0_en", bif.lane_enable, 4'b0001);
    chk("mk_lane0_pc_off", bif.pc_offset, 0);
    bif.lane_mask = 4'b1111;
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("mk_lane2_off", bif.lane_offset, 2);
    chk("mk_lane2_en", bif.lane_enable, 4'b0100);
    chk("mk_lane2_pc_off", bif.pc_offset, 3);
    bif.lane_mask = 4'b0000;
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("mk_pc_16", pc, 16);
    chk("mk_zero_issue", bif.issue_valid, 1);
    chk("mk_zero_en", bif.lane_enable, 0);
    chk("mk_zero_pc_off", bif.pc_offset, 3);
    bif.lane_mask = 4'b0011;
    drive(0, 1, 1, 0, 0, 8'h00);
    chk("mk_pc_17", pc, 17);
    chk("mk_vec_en", bif.lane_enable, 4'b0011);
    bif.lane_mask = 4'hF;
`endif

    drive(0, 0, 0, 0, 0, 8'h00);
    chk("idle_issue", bif.issue_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
